// File: rtl/bitonic_sort4_pipe.sv
// Three-stage pipelined 4-key bitonic sorter with global enable and ready/valid backpressure.
// Each stage register holds one compare-exchange layer result; the whole pipe advances or holds as one.
module bitonic_sort4_pipe #(
    parameter int WIDTH   = 32,
    parameter bit DESCEND = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    input  logic               in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [4*WIDTH-1:0] out_data,
    input  logic               out_ready,
    output logic [15:0]        out_count
);

    localparam int DW = 4 * WIDTH;

    // Returns {new lane b, new lane a}; equal keys never swap.
    function automatic logic [2*WIDTH-1:0] cas(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic up);
        logic dir;
        dir = up ^ DESCEND;
        if (dir ? (a > b) : (a < b))
            return {a, b};
        else
            return {b, a};
    endfunction

    function automatic logic [DW-1:0] cas_pair(input logic [DW-1:0] x,
                                               input int i,
                                               input int j,
                                               input logic up);
        logic [2*WIDTH-1:0] r;
        logic [DW-1:0]      y;
        r = cas(x[i*WIDTH +: WIDTH], x[j*WIDTH +: WIDTH], up);
        y = x;
        y[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
        y[j*WIDTH +: WIDTH] = r[2*WIDTH-1:WIDTH];
        return y;
    endfunction

    function automatic logic [DW-1:0] layer1(input logic [DW-1:0] x);
        return cas_pair(cas_pair(x, 0, 1, 1'b1), 2, 3, 1'b0);
    endfunction

    function automatic logic [DW-1:0] layer2(input logic [DW-1:0] x);
        return cas_pair(cas_pair(x, 0, 2, 1'b1), 1, 3, 1'b1);
    endfunction

    function automatic logic [DW-1:0] layer3(input logic [DW-1:0] x);
        return cas_pair(cas_pair(x, 0, 1, 1'b1), 2, 3, 1'b1);
    endfunction

    logic          s1_vld_q, s2_vld_q, s3_vld_q;
    logic [DW-1:0] s1_data_q, s2_data_q, s3_data_q;
    logic [15:0]   cnt_q, cnt_d;
    logic          adv;

    assign adv       = en & (~s3_vld_q | out_ready);
    assign in_ready  = adv;
    assign out_valid = s3_vld_q;
    assign out_data  = s3_data_q;
    assign out_count = cnt_q;

    // No bubble collapse: every stage moves together so the data path stays a plain shift.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s2_data_q <= '0;
            s3_data_q <= '0;
        end else if (adv) begin
            s1_vld_q  <= in_valid;
            s2_vld_q  <= s1_vld_q;
            s3_vld_q  <= s2_vld_q;
            s1_data_q <= layer1(in_data);
            s2_data_q <= layer2(s1_data_q);
            s3_data_q <= layer3(s2_data_q);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (s3_vld_q && out_ready && en && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: tb/tb_bitonic_sort4_pipe.sv
// Scoreboard bench for bitonic_sort4_pipe: ascending and descending instances share one stimulus stream.
module tb_bitonic_sort4_pipe;

    logic         clk = 1'b0;
    logic         resetn, en, in_valid, out_ready;
    logic [127:0] in_data;
    logic         in_ready_a, out_valid_a, in_ready_d, out_valid_d;
    logic [127:0] out_data_a, out_data_d;
    logic [15:0]  out_count_a, out_count_d;

    bitonic_sort4_pipe #(.WIDTH(32), .DESCEND(1'b0)) u_asc (
        .clk(clk), .resetn(resetn), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_ready(out_ready), .out_count(out_count_a));

    bitonic_sort4_pipe #(.WIDTH(32), .DESCEND(1'b1)) u_dsc (
        .clk(clk), .resetn(resetn), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_d), .out_valid(out_valid_d), .out_data(out_data_d),
        .out_ready(out_ready), .out_count(out_count_d));

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] asc;
        logic [127:0] dsc;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           nchecks = 0;
    int           nerr = 0;
    int           cyc = 0;
    int           vcnt = 0;
    bit           mon_on = 1'b1;
    bit           lat_chk = 1'b0;
    logic [127:0] last_a, last_d;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_sort(input logic [127:0] x, input bit desc);
        logic [31:0]  v[4];
        logic [31:0]  t;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) v[i] = x[i*32 +: 32];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (desc ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = v[i];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (resetn && en && out_valid_a && out_ready) begin
            vcnt++;
            last_a = out_data_a;
            last_d = out_data_d;
            if (mon_on) begin
                check_eq("valid_match", out_valid_d, 1'b1);
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check_eq("asc_data", out_data_a, e.asc);
                    check_eq("dsc_data", out_data_d, e.dsc);
                    if (lat_chk) check_eq("latency", cyc - e.acc, 3);
                end
            end
        end
        if (resetn && mon_on && in_valid && in_ready_a) begin
            e.asc = model_sort(in_data, 1'b0);
            e.dsc = model_sort(in_data, 1'b1);
            e.acc = cyc;
            sb.push_back(e);
        end
    end

    task automatic drive_group(input logic [127:0] d);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk);
            #1;
        end
        if (!acc) check_eq("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    function automatic logic [127:0] rand_group();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 3) == 0) r[63:32] = r[31:0];
        return r;
    endfunction

    initial begin
        logic [127:0] snap_d;
        logic         snap_v;
        logic [15:0]  snap_c;
        int           v0;
        bit           seen;

        resetn    = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        #1;
        check_eq("rst_out_valid", out_valid_a, 1'b0);
        check_eq("rst_out_data", out_data_a, 128'd0);
        check_eq("rst_out_count", out_count_a, 16'd0);
        check_eq("rst_in_ready", in_ready_a, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Basic ascending: 3,7,1,5
        lat_chk = 1'b1;
        drive_group({32'd5, 32'd1, 32'd7, 32'd3});
        in_valid = 1'b0;
        wait_drain();
        check_eq("basic_asc", last_a, {32'd7, 32'd5, 32'd3, 32'd1});
        check_eq("basic_count", out_count_a, 16'd1);

        // Duplicates and unsigned compare: 9,9,0,FFFFFFFF
        drive_group({32'hFFFFFFFF, 32'd0, 32'd9, 32'd9});
        in_valid = 1'b0;
        wait_drain();
        check_eq("dup_dsc", last_d, {32'd0, 32'd9, 32'd9, 32'hFFFFFFFF});
        check_eq("dup_asc", last_a, {32'hFFFFFFFF, 32'd9, 32'd9, 32'd0});
        check_eq("dup_count", out_count_d, 16'd2);

        // Streaming 8 back-to-back groups
        v0 = vcnt;
        for (int g = 0; g < 8; g++) drive_group(rand_group());
        in_valid = 1'b0;
        wait_drain();
        check_eq("stream_nout", vcnt - v0, 8);
        check_eq("stream_count", out_count_a, 16'd10);
        lat_chk = 1'b0;

        // Backpressure: 5-cycle stall on the first output of the burst
        fork
            begin
                for (int g = 0; g < 6; g++) drive_group(rand_group());
                in_valid = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(posedge clk);
                    #1;
                    seen = out_valid_a;
                end
                check_eq("bp_seen", seen, 1'b1);
                out_ready = 1'b0;
                snap_d    = out_data_a;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check_eq("bp_in_ready", in_ready_a, 1'b0);
                    check_eq("bp_hold", out_data_a, snap_d);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check_eq("bp_count", out_count_a, 16'd16);

        // Enable freeze with two groups in flight, then async reset
        drive_group(rand_group());
        drive_group(rand_group());
        en       = 1'b0;
        in_data  = rand_group();
        snap_v   = out_valid_a;
        snap_d   = out_data_a;
        snap_c   = out_count_a;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("en_in_ready", in_ready_a, 1'b0);
            check_eq("en_valid", out_valid_a, snap_v);
            check_eq("en_data", out_data_a, snap_d);
            check_eq("en_count", out_count_a, snap_c);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        en        = 1'b1;
        seen      = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = out_valid_a;
        end
        check_eq("en_resume", seen, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("arst_valid", out_valid_a, 1'b0);
        check_eq("arst_data", out_data_a, 128'd0);
        check_eq("arst_count", out_count_a, 16'd0);
        sb.delete();
        @(posedge clk);
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;
        v0        = vcnt;
        repeat (8) @(posedge clk);
        #1;
        check_eq("post_rst_nout", vcnt - v0, 0);
        check_eq("post_rst_valid", out_valid_a, 1'b0);

        // Counter saturation
        mon_on   = 1'b0;
        in_valid = 1'b1;
        in_data  = rand_group();
        repeat (65545) @(posedge clk);
        #1;
        check_eq("sat_count", out_count_a, 16'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        check_eq("sat_hold", out_count_d, 16'hFFFF);
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
